// File: rtl/data_memory_if.sv
// CPU <-> data memory load/store bus.
// Master: CPU drives address/store data/requests; slave returns load data and status.
// Optional: DMEM_STATS_EN adds read_count/write_count returned by the slave.
interface data_memory_if;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;
    logic        stall;
    logic        rd_valid;
    logic        misaligned;
`ifdef DMEM_STATS_EN
    logic [15:0] read_count;
    logic [15:0] write_count;
`endif

    modport master (
        output data_addr, data_in, mem_read, mem_write,
`ifdef DMEM_STATS_EN
        input  read_count, write_count,
`endif
        input  data_out, stall, rd_valid, misaligned
    );

    modport slave (
        input  data_addr, data_in, mem_read, mem_write,
`ifdef DMEM_STATS_EN
        output read_count, write_count,
`endif
        output data_out, stall, rd_valid, misaligned
    );
endinterface

// File: rtl/data_memory.sv
// Word-organised data memory with multi-cycle stalled loads and a zero-fill
// sweep after reset.
// Ports: clk, rst (sync, active-high), bus (data_memory_if.slave):
//   data_addr/data_in/mem_read/mem_write in; data_out/stall/rd_valid/misaligned out.
// Optional: define DMEM_STATS_EN for saturating read_count/write_count outputs.
module data_memory #(
    parameter int DEPTH        = 256,
    parameter int READ_LATENCY = 2
) (
    input  logic         clk,
    input  logic         rst,
    data_memory_if.slave bus
);

    localparam int ADDR_W = $clog2(DEPTH);
    // Countdown holds READ_LATENCY-2 at most: the request cycle is the first stall cycle.
    localparam int CNT_W  = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'((READ_LATENCY >= 2) ? READ_LATENCY - 2 : 0);

    typedef enum logic [1:0] {
        S_INIT,
        S_IDLE,
        S_READ,
        S_DONE
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   init_cnt_q;
    logic [ADDR_W-1:0]   idx_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [31:0]         data_out_q;
    logic                rd_valid_q;
    logic                mis_q;
    logic [31:0]         mem_q [DEPTH];

    logic                aligned;
    logic [ADDR_W-1:0]   word;
    logic                wr_acc;
    logic                rd_acc;
    logic                mis_hit;
    logic                mem_we;
    logic [ADDR_W-1:0]   mem_wa;
    logic [31:0]         mem_wd;
    logic                stall;
    logic                unused_addr;

    assign aligned = (bus.data_addr[1:0] == 2'b00);
    assign word    = bus.data_addr[ADDR_W+1:2];
    // Upper address bits alias onto the same words.
    assign unused_addr = ^bus.data_addr[31:ADDR_W+2];

    assign wr_acc  = (state_q == S_IDLE) && bus.mem_write && aligned;
    assign rd_acc  = (state_q == S_IDLE) && bus.mem_read
                     && !bus.mem_write && aligned;
    assign mis_hit = (state_q == S_IDLE) && !aligned
                     && (bus.mem_read || bus.mem_write);

    // Single write port shared by the init sweep and CPU stores.
    always_comb begin
        mem_we = 1'b0;
        mem_wa = word;
        mem_wd = bus.data_in;
        if (!rst) begin
            if (state_q == S_INIT) begin
                mem_we = 1'b1;
                mem_wa = init_cnt_q;
                mem_wd = '0;
            end else if (wr_acc) begin
                mem_we = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[mem_wa] <= mem_wd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            init_cnt_q <= '0;
            idx_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
            rd_valid_q <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (mis_hit) begin
                mis_q <= 1'b1;
            end
            unique case (state_q)
                S_INIT: begin
                    init_cnt_q <= init_cnt_q + 1'b1;
                    if (init_cnt_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= S_IDLE;
                    end
                end
                S_IDLE: begin
                    if (rd_acc) begin
                        idx_q <= word;
                        cnt_q <= CNT_LOAD;
                        if (READ_LATENCY == 1) begin
                            state_q    <= S_DONE;
                            data_out_q <= mem_q[word];
                            rd_valid_q <= 1'b1;
                        end else begin
                            state_q <= S_READ;
                        end
                    end
                end
                S_READ: begin
                    if (cnt_q == '0) begin
                        state_q    <= S_DONE;
                        data_out_q <= mem_q[idx_q];
                        rd_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_INIT;
                end
            endcase
        end
    end

    // Stall rises in the request cycle itself so the CPU holds the load.
    always_comb begin
        stall = 1'b1;
        unique case (state_q)
            S_IDLE:  stall = rd_acc;
            S_DONE:  stall = 1'b0;
            default: stall = 1'b1;
        endcase
    end

    assign bus.stall      = stall;
    assign bus.data_out   = data_out_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.misaligned = mis_q;

`ifdef DMEM_STATS_EN
    logic [15:0] rd_cnt_q;
    logic [15:0] wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            if (state_q == S_DONE && rd_cnt_q != 16'hFFFF) begin
                rd_cnt_q <= rd_cnt_q + 16'd1;
            end
            if (wr_acc && wr_cnt_q != 16'hFFFF) begin
                wr_cnt_q <= wr_cnt_q + 16'd1;
            end
        end
    end

    assign bus.read_count  = rd_cnt_q;
    assign bus.write_count = wr_cnt_q;
`else
    // Statistics counters are not built.
`endif

endmodule

// File: tb/tb_data_memory.sv
// Scoreboard bench for data_memory: directed scenarios plus random traffic
// against an array model; a monitor checks every load completion.
module tb_data_memory;
    localparam int DEPTH = 256;
    localparam int RL    = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    data_memory_if bus();

    data_memory #(.DEPTH(DEPTH), .READ_LATENCY(RL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] ref_mem [DEPTH];
    logic [31:0] exp_q [$];
    logic [31:0] last_load;
    logic        exp_mis;
    int          rd_model;
    int          wr_model;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    // Monitor: every load completion must match the oldest expected value.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (bus.rd_valid === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_rd_valid: got data_out %h expected no load",
                             bus.data_out);
                end else begin
                    e = exp_q.pop_front();
                    check("load_data", bus.data_out, e);
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic do_reset(input int hold);
        int cycles;
        rst = 1'b1;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        repeat (hold) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        exp_q.delete();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        last_load = '0;
        exp_mis   = 1'b0;
        rd_model  = 0;
        wr_model  = 0;
        @(negedge clk);
        check("rst_data_out", bus.data_out, 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_misaligned", 32'(bus.misaligned), 32'd0);
`ifdef DMEM_STATS_EN
        check("rst_read_count", 32'(bus.read_count), 32'd0);
        check("rst_write_count", 32'(bus.write_count), 32'd0);
`endif
        cycles = 0;
        while (bus.stall === 1'b1 && cycles < 1000) begin
            cycles++;
            @(negedge clk);
        end
        check("init_stall_cycles", 32'(cycles), 32'(DEPTH));
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                            input logic rd_too);
        bus.data_addr = a;
        bus.data_in   = d;
        bus.mem_write = 1'b1;
        bus.mem_read  = rd_too;
        @(negedge clk);
        check("wr_stall", 32'(bus.stall), 32'd0);
        check("wr_rd_valid", 32'(bus.rd_valid), 32'd0);
        @(posedge clk);
        #1;
        bus.mem_write = 1'b0;
        bus.mem_read  = 1'b0;
        if (a[1:0] == 2'b00) begin
            ref_mem[widx(a)] = d;
            wr_model++;
        end else begin
            exp_mis = 1'b1;
        end
        check("wr_misaligned", 32'(bus.misaligned), 32'(exp_mis));
    endtask

    task automatic do_read(input logic [31:0] a);
        int   cycles;
        logic ok;
        ok = (a[1:0] == 2'b00);
        bus.data_addr = a;
        bus.mem_read  = 1'b1;
        bus.mem_write = 1'b0;
        if (ok) begin
            last_load = ref_mem[widx(a)];
            exp_q.push_back(last_load);
            rd_model++;
        end
        cycles = 0;
        @(negedge clk);
        while (bus.stall === 1'b1 && cycles < 20) begin
            cycles++;
            @(negedge clk);
        end
        check("rd_stall_cycles", 32'(cycles), ok ? 32'(RL) : 32'd0);
        check("rd_valid_timing", 32'(bus.rd_valid), 32'(ok));
        check("rd_data_out_held", bus.data_out, last_load);
        @(posedge clk);
        #1;
        bus.mem_read = 1'b0;
        if (!ok) exp_mis = 1'b1;
        check("rd_misaligned", 32'(bus.misaligned), 32'(exp_mis));
    endtask

    initial begin
        logic [31:0] a;
        int          op;
        bus.data_addr = '0;
        bus.data_in   = '0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;

        do_reset(2);
        do_read(32'h10);

        do_write(32'h20, 32'hDEADBEEF, 1'b0);
        do_read(32'h20);

        do_read(32'h22);
        do_write(32'h13, 32'hFFFFFFFF, 1'b0);
        do_read(32'h10);

        do_write(32'h40, 32'h12345678, 1'b1);
        do_read(32'h40);

        do_write(32'h0, 32'hA5A5A5A5, 1'b0);
        do_read(32'h400);

        for (int i = 0; i < 80; i++) begin
            a = 32'($urandom_range(0, 15)) << 2;
            a = a | (32'($urandom_range(0, 3)) << 10);
            if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
            op = $urandom_range(0, 9);
            if (op < 4) do_write(a, $urandom, 1'b0);
            else if (op < 8) do_read(a);
            else do_write(a, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
`ifdef DMEM_STATS_EN
        check("read_count", 32'(bus.read_count), 32'(rd_model));
        check("write_count", 32'(bus.write_count), 32'(wr_model));
`endif

        // Reset lands in cycle T+1 of a load: the load must never complete.
        bus.data_addr = 32'h20;
        bus.mem_read  = 1'b1;
        @(posedge clk);
        #1;
        do_reset(1);
        do_read(32'h20);
        do_read(32'h0);

        repeat (4) @(posedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Word-organised data memory that sits directly downstream of the CPU's load/store path.
- Consumes the CPU's data_addr, data_out, mem_read and mem_write; returns load data to the CPU's data_in.
- Models a multi-cycle read with a stall handshake.
- Zero-fills its storage after reset with a sequential init sweep.

Parameters:
DEPTH, 256, number of 32-bit words; power of two, >=2; ADDR_W = log2(DEPTH)
READ_LATENCY, 2, cycles stall is held for a read (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous, active-high reset
data_addr  input  32  byte address from CPU; word index = data_addr[ADDR_W+1:2], upper bits ignored (aliasing)
data_in  input  32  store data from CPU
mem_read  input  1  load request, held by CPU while stall=1
mem_write  input  1  store request
data_out  output  32  load data to CPU
stall  output  1  CPU must hold the current instruction while high
rd_valid  output  1  one-cycle pulse: data_out carries the completed load
misaligned  output  1  sticky: an access with data_addr[1:0]!=0 was seen

Behaviour:
- Reset, sampled on clk edge: state=INIT, init_cnt=0, data_out=0, rd_valid=0, misaligned=0, stall=1.
- Reset in any state, including mid-read, aborts the access and restarts INIT.
- INIT: writes 0 to word init_cnt each cycle; init_cnt increments; after word DEPTH-1 is written -> IDLE.
- INIT lasts exactly DEPTH cycles; stall=1 throughout; requests are ignored.
- IDLE, mem_write=1, aligned: word written at end of cycle; single cycle; stall=0.
- IDLE, mem_read=1, mem_write=0, aligned (request cycle T):
  - stall=1 combinationally in cycle T; word index latched at end of T.
  - Then READ state with a countdown.
  - stall is high for cycles T..T+READ_LATENCY-1.
  - Cycle T+READ_LATENCY is DONE: stall=0, rd_valid=1, data_out=mem[latched index].
- DONE: the CPU still presents the same load; it is not re-accepted. Next cycle -> IDLE.
- Back-to-back loads cost READ_LATENCY+1 cycles each.
- mem_read and mem_write both high in IDLE: write performed, read ignored, no stall.
- Misaligned access (data_addr[1:0]!=0, read or write): dropped; no memory change; no stall; misaligned set to 1 at end of cycle and held until reset.
- data_out holds the last completed load value between loads; only changes on DONE or reset.
- Inputs are not sampled in READ/DONE other than the latched index; a write request arriving there is ignored. The CPU is stalled, so this cannot occur legally.
- Address aliasing: byte address 4*DEPTH maps to word 0.

Optional Feature:
DMEM_STATS_EN
- Defined: adds outputs read_count[15:0] and write_count[15:0].
  - read_count increments on each DONE cycle; write_count increments on each accepted write.
  - Both saturate at 0xFFFF, clear on reset, and do not count during INIT or for dropped misaligned accesses.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset then idle, DEPTH=256 -> stall=1 for exactly 256 cycles, then 0; read addr 0x10 -> data_out=0x00000000 with rd_valid on cycle T+2.
- Write 0xDEADBEEF @0x20 -> no stall; later read 0x20 -> stall high 2 cycles; rd_valid and data_out=0xDEADBEEF in 3rd cycle.
- Read 0x22 -> misaligned=1 and stays 1; no stall; data_out unchanged. Write 0x13 -> memory untouched (verify by reading 0x10).
- mem_read=mem_write=1, addr 0x40, data 0x12345678 -> no stall, rd_valid=0; subsequent read 0x40 returns 0x12345678.
- Write 0xA5A5A5A5 @0x0, then read 0x400 -> returns 0xA5A5A5A5 (alias).
- Assert rst in cycle T+1 of a read -> rd_valid never pulses, data_out=0, stall=1 for 256 cycles; earlier-written word reads back 0.
  - With DMEM_STATS_EN defined, both counters read 0 after this reset.
